// File: rtl/prog_inst_mem_if.sv
// Fetch and byte-load bundle for the loadable instruction memory.
// master = PC stage / program loader side, slave = memory side.
interface prog_inst_mem_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_gnt;
    logic              fetch_valid;
    logic              fetch_ready;
    logic [DATA_W-1:0] fetch_inst;
    logic              fetch_err;
    logic              load_start;
    logic              load_byte_valid;
    logic [7:0]        load_byte;
    logic              load_end;
    logic              load_busy;
    logic [CNT_W-1:0]  load_words;

    modport master (
        output fetch_req, fetch_addr, fetch_ready,
        output load_start, load_byte_valid, load_byte, load_end,
        input  fetch_gnt, fetch_valid, fetch_inst, fetch_err,
        input  load_busy, load_words
    );

    modport slave (
        input  fetch_req, fetch_addr, fetch_ready,
        input  load_start, load_byte_valid, load_byte, load_end,
        output fetch_gnt, fetch_valid, fetch_inst, fetch_err,
        output load_busy, load_words
    );
endinterface

// File: rtl/prog_inst_mem.sv
// Loadable word-addressed instruction RAM with a byte-serial load port
// and a registered valid/ready fetch port that flags faulting fetches.
module prog_inst_mem #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 64,
    parameter int                ADDR_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input logic            clk,
    input logic            rst_n,
    prog_inst_mem_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int SH    = $clog2(NB);
    localparam int BC_W  = (NB > 1) ? $clog2(NB) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_words;
    logic [DATA_W-1:0]  r_buf;
    logic [BC_W-1:0]    r_bcnt;
    logic               r_valid;
    logic [DATA_W-1:0]  r_inst;
    logic               r_err;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_run;
    logic               w_load;
    logic               w_byte;
    logic               w_end;
    logic               w_last_byte;
    logic               w_last_word;
    logic               w_wr;
    logic [DATA_W-1:0]  w_word;
    logic [ADDR_W-1:0]  w_off;
    logic [ADDR_W-1:0]  w_idx;
    logic               w_fault;
    logic               w_gnt;

    assign w_run  = (r_state == S_RUN);
    assign w_load = (r_state == S_LOAD);

    // load_start always wins, so bytes and load_end in its cycle are dropped
    assign w_byte = w_load && !bus.load_start && bus.load_byte_valid;
    assign w_end  = w_load && !bus.load_start && bus.load_end;

    assign w_last_byte = w_byte && (r_bcnt == BC_W'(NB - 1));
    assign w_last_word = (r_ptr == PTR_W'(DEPTH - 1));
    assign w_word = r_buf |
        (w_byte ? (DATA_W'(bus.load_byte) << {r_bcnt, 3'b000}) : '0);
    assign w_wr = w_last_byte ||
        (w_end && (w_byte || (r_bcnt != '0)));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_RUN: begin
                if (bus.load_start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (bus.load_start)
                    w_state_nxt = S_LOAD;
                else if (w_end || (w_wr && w_last_word))
                    w_state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RUN;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_words <= '0;
            r_buf   <= '0;
            r_bcnt  <= '0;
        end else if (bus.load_start) begin
            r_ptr   <= '0;
            r_words <= '0;
            r_buf   <= '0;
            r_bcnt  <= '0;
        end else if (w_wr) begin
            r_ptr   <= r_ptr + 1'b1;
            r_words <= r_words + 1'b1;
            r_buf   <= '0;
            r_bcnt  <= '0;
        end else if (w_byte) begin
            r_buf   <= w_word;
            r_bcnt  <= r_bcnt + 1'b1;
        end
    end

    // RAM contents survive reset so a program can outlive a core reset
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_ptr] <= w_word;
    end

    assign w_off   = bus.fetch_addr & ADDR_W'(NB - 1);
    assign w_idx   = bus.fetch_addr >> SH;
    assign w_fault = (w_off != '0) || (w_idx >= ADDR_W'(DEPTH));
    assign w_gnt   = w_run && bus.fetch_req && !bus.load_start &&
                     (!r_valid || bus.fetch_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_WORD;
            r_err   <= 1'b0;
        end else if (bus.load_start) begin
            r_valid <= 1'b0;
        end else if (w_gnt) begin
            r_valid <= 1'b1;
            r_err   <= w_fault;
            r_inst  <= w_fault ? NOP_WORD : r_mem[w_idx[PTR_W-1:0]];
        end else if (r_valid && bus.fetch_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.fetch_gnt   = w_gnt;
    assign bus.fetch_valid = r_valid;
    assign bus.fetch_inst  = r_inst;
    assign bus.fetch_err   = r_err;
    assign bus.load_busy   = w_load;
    assign bus.load_words  = r_words;
endmodule

// File: tb/tb_prog_inst_mem.sv
// Bench for prog_inst_mem: directed scenarios plus random traffic,
// checked every cycle against a queue/array model of the memory.
module tb_prog_inst_mem;
    localparam int DW = 32;
    localparam int DP = 16;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_inst_mem_if #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) bus ();

    prog_inst_mem #(
        .DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .NOP_WORD(32'h0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_mem [DP];
    logic [7:0]  m_q [$];
    int          m_ptr;
    int          m_words;
    logic        m_busy;
    logic        m_valid;
    logic [31:0] m_inst;
    logic        m_err;

    logic [31:0] d8 [8];
    logic [31:0] w64 [DP];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic exp_gnt();
        return !m_busy && bus.fetch_req && !bus.load_start &&
               (!m_valid || bus.fetch_ready);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ptr = 0;
        m_words = 0;
        m_busy = 1'b0;
        m_valid = 1'b0;
        m_inst = 32'h0;
        m_err = 1'b0;
    endtask

    task automatic model_step();
        logic        g;
        logic [31:0] w;
        logic [31:0] a;
        g = exp_gnt();
        a = bus.fetch_addr;
        if (bus.load_start) begin
            m_busy = 1'b1;
            m_words = 0;
            m_ptr = 0;
            m_q.delete();
            m_valid = 1'b0;
        end else if (m_busy) begin
            if (bus.load_byte_valid) m_q.push_back(bus.load_byte);
            if (m_q.size() == 4 || (bus.load_end && m_q.size() > 0)) begin
                w = 32'h0;
                for (int k = 0; k < m_q.size(); k++) w[8*k +: 8] = m_q[k];
                m_mem[m_ptr] = w;
                m_ptr++;
                m_words++;
                m_q.delete();
                if (m_ptr == DP) m_busy = 1'b0;
            end
            if (bus.load_end) m_busy = 1'b0;
        end else if (g) begin
            m_valid = 1'b1;
            if ((a % 4) != 0 || (a / 4) >= DP) begin
                m_err = 1'b1;
                m_inst = 32'h0;
            end else begin
                m_err = 1'b0;
                m_inst = m_mem[a / 4];
            end
        end else if (m_valid && bus.fetch_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("gnt", 32'(bus.fetch_gnt), 32'(exp_gnt()));
            chk("valid", 32'(bus.fetch_valid), 32'(m_valid));
            chk("inst", bus.fetch_inst, m_inst);
            chk("err", 32'(bus.fetch_err), 32'(m_err));
            chk("busy", 32'(bus.load_busy), 32'(m_busy));
            chk("words", 32'(bus.load_words), 32'(m_words));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clr();
        bus.fetch_req = 1'b0;
        bus.fetch_addr = '0;
        bus.fetch_ready = 1'b0;
        bus.load_start = 1'b0;
        bus.load_byte_valid = 1'b0;
        bus.load_byte = 8'h00;
        bus.load_end = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic start_load();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic end_load();
        bus.load_end = 1'b1;
        tick();
        bus.load_end = 1'b0;
    endtask

    task automatic send_byte(logic [7:0] b);
        bus.load_byte_valid = 1'b1;
        bus.load_byte = b;
        tick();
        bus.load_byte_valid = 1'b0;
    endtask

    task automatic send_word(logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic fetch(logic [31:0] a);
        bus.fetch_req = 1'b1;
        bus.fetch_addr = a;
        bus.fetch_ready = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
    endtask

    initial begin
        clr();
        model_reset();
        fork
            compare_loop();
        join_none
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_valid", 32'(bus.fetch_valid), 32'h0);
        chk("rst_inst", bus.fetch_inst, 32'h0);
        chk("rst_busy", 32'(bus.load_busy), 32'h0);
        chk("rst_words", 32'(bus.load_words), 32'h0);

        start_load();
        chk("busy_up", 32'(bus.load_busy), 32'h1);
        send_byte(8'h14);
        send_byte(8'h00);
        send_byte(8'h83);
        send_byte(8'h04);
        end_load();
        tick();
        chk("one_word_busy", 32'(bus.load_busy), 32'h0);
        chk("one_word_cnt", 32'(bus.load_words), 32'h1);
        chk("model_mem0", m_mem[0], 32'h0483_0014);
        fetch(32'h0);
        chk("fetch0_inst", bus.fetch_inst, 32'h0483_0014);
        chk("fetch0_err", 32'(bus.fetch_err), 32'h0);
        tick();

        start_load();
        for (int i = 0; i < 8; i++) begin
            d8[i] = $urandom;
            send_word(d8[i]);
        end
        end_load();
        chk("eight_cnt", 32'(bus.load_words), 32'd8);
        bus.fetch_req = 1'b1;
        bus.fetch_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.fetch_addr = 32'(i * 4);
            tick();
            chk("b2b_inst", bus.fetch_inst, d8[i]);
        end
        bus.fetch_req = 1'b0;
        tick();

        fetch(32'h2);
        chk("mis_err", 32'(bus.fetch_err), 32'h1);
        chk("mis_inst", bus.fetch_inst, 32'h0);
        fetch(32'h40);
        chk("oor_err", 32'(bus.fetch_err), 32'h1);
        chk("oor_inst", bus.fetch_inst, 32'h0);
        tick();

        fetch(32'h4);
        bus.fetch_req = 1'b1;
        bus.fetch_addr = 32'h8;
        bus.fetch_ready = 1'b0;
        repeat (3) begin
            #1;
            chk("stall_gnt", 32'(bus.fetch_gnt), 32'h0);
            chk("stall_inst", bus.fetch_inst, d8[1]);
            tick();
        end
        bus.fetch_ready = 1'b1;
        #1;
        chk("resume_gnt", 32'(bus.fetch_gnt), 32'h1);
        tick();
        chk("resume_inst", bus.fetch_inst, d8[2]);
        bus.fetch_req = 1'b0;
        tick();

        start_load();
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        end_load();
        chk("partial_cnt", 32'(bus.load_words), 32'h1);
        fetch(32'h0);
        chk("partial_inst", bus.fetch_inst, 32'h00CC_BBAA);
        tick();

        start_load();
        for (int i = 0; i < DP; i++) begin
            w64[i] = $urandom;
            send_word(w64[i]);
        end
        chk("full_busy", 32'(bus.load_busy), 32'h0);
        chk("full_cnt", 32'(bus.load_words), 32'd16);
        send_byte(8'hEE);
        chk("extra_cnt", 32'(bus.load_words), 32'd16);
        fetch(32'd60);
        chk("full_last", bus.fetch_inst, w64[15]);
        fetch(32'd0);
        chk("full_first", bus.fetch_inst, w64[0]);
        tick();

        start_load();
        send_byte(8'h11);
        send_byte(8'h22);
        do_reset();
        chk("midrst_busy", 32'(bus.load_busy), 32'h0);
        chk("midrst_valid", 32'(bus.fetch_valid), 32'h0);
        chk("midrst_words", 32'(bus.load_words), 32'h0);
        fetch(32'h4);
        chk("retained1", bus.fetch_inst, w64[1]);
        fetch(32'h0);
        chk("retained0", bus.fetch_inst, w64[0]);
        tick();

        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 99) < 3) begin
                start_load();
                for (int j = 0; j < int'($urandom_range(1, 20)); j++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    send_byte(8'($urandom));
                end
                end_load();
            end else begin
                bus.fetch_req = ($urandom_range(0, 99) < 70);
                bus.fetch_ready = ($urandom_range(0, 99) < 70);
                bus.load_byte_valid = $urandom_range(0, 1) == 1;
                bus.load_byte = 8'($urandom);
                case ($urandom_range(0, 9))
                    0: bus.fetch_addr =
                        32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                    1: bus.fetch_addr = 32'($urandom_range(16, 1000) * 4);
                    default: bus.fetch_addr = 32'($urandom_range(0, 15) * 4);
                endcase
                tick();
                bus.load_byte_valid = 1'b0;
            end
        end
        clr();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
